con_modn_updown: RTL

- Parametrised modulo-N up/down counter; successor to the fixed 3-bit mod-7 JK counter.
- Generalised in width and modulus. Adds enable, direction, parallel load, synchronous preset, terminal-count and wrap-carry outputs.
- Used as a building block for dividers, sequencers and timebases in the same design tree.

---
 rtl/con_modn_updown.sv | 97 +++++++++
 1 files changed

// File: rtl/con_modn_updown.sv
// Parametrised modulo-N up/down counter with preset, parallel load, terminal count and wrap carry.
// Optional macro MODN_GRAY_OUT_EN: q presents the Gray code of the count instead of binary.
module con_modn_updown #(
  parameter int WIDTH = 3,
  parameter int MOD   = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             set,
  input  logic             load,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             carry,
  output logic             load_err
);

  localparam int             WP1   = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_W = WP1'(MOD);

  if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
    $error("con_modn_updown: MOD must satisfy 2 <= MOD <= 2**WIDTH");
  end

  logic [WIDTH-1:0] count, count_nxt;
  logic             carry_nxt, load_err_nxt;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    count_nxt    = count;
    carry_nxt    = 1'b0;
    load_err_nxt = 1'b0;
    if (set) begin
      count_nxt = MAX;
    end else if (load) begin
      // Out-of-range loads land on 0 so the count never leaves 0..MOD-1.
      if ({1'b0, d} < MOD_W) begin
        count_nxt = d;
      end else begin
        count_nxt    = '0;
        load_err_nxt = 1'b1;
      end
    end else if (en) begin
      if (up_dn) begin
        if (count == MAX) begin
          count_nxt = '0;
          carry_nxt = 1'b1;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          count_nxt = MAX;
          carry_nxt = 1'b1;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      count    <= '0;
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= count_nxt;
      carry    <= carry_nxt;
      load_err <= load_err_nxt;
    end
  end

  assign tc = en & ~set & ~load & (up_dn ? (count == MAX) : (count == '0));

`ifdef MODN_GRAY_OUT_EN
  logic [WIDTH-1:0] gray_q;

  // Gray register is fed from the next binary count so it tracks count on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q <= '0;
    end else begin
      gray_q <= count_nxt ^ (count_nxt >> 1);
    end
  end

  assign q = gray_q;
`else
  assign q = count;
`endif

endmodule
